// File: rtl/game_sequencer.sv
// Round controller for the memorization game: latches targets, sequences show/enter/check/result, keeps score and lives.
// Optional build macro GAME_SPEEDUP_EN shortens the show phase as the score grows.
module game_sequencer #(
    parameter int SHOW_TICKS   = 6,
    parameter int RESULT_TICKS = 4,
    parameter int LIVES        = 3,
    parameter int SCORE_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blinkTick,
    input  logic               start,
    input  logic               submit,
    input  logic [15:0]        randInt,
    input  logic               correct,
    output logic [15:0]        targetInt,
    output logic               displayPhase,
    output logic               inputReady,
    output logic               lastCorrect,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         livesLeft,
    output logic               gameOver
);

    localparam int CNT_MAX = (SHOW_TICKS > RESULT_TICKS) ? SHOW_TICKS : RESULT_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHOW   = 3'd1;
    localparam logic [2:0] S_ENTER  = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_SHOW   = CNT_W'(SHOW_TICKS);
    localparam logic [CNT_W-1:0]   CNT_RESULT = CNT_W'(RESULT_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

    logic [2:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [15:0]        target_reg, target_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [1:0]         lives_reg, lives_next;
    logic               last_reg, last_next;
    logic               disp_reg, ready_reg, over_reg;
    logic [CNT_W-1:0]   show_len;

`ifdef GAME_SPEEDUP_EN
    // Show length for the next round: max(2, SHOW_TICKS - score), using the already-updated score.
    logic [31:0] score_ext;
    assign score_ext = 32'(score_reg);

    always_comb begin
        show_len = CNT_W'(2);
        if (score_ext + 32'd2 < 32'(SHOW_TICKS)) begin
            show_len = CNT_W'(32'(SHOW_TICKS) - score_ext);
        end
    end
`else
    assign show_len = CNT_SHOW;
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        score_next  = score_reg;
        lives_next  = lives_reg;
        last_next   = last_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    target_next = randInt;
                    cnt_next    = show_len;
                    state_next  = S_SHOW;
                end
            end

            S_SHOW: begin
                if (blinkTick) begin
                    if (cnt_reg <= CNT_ONE) begin
                        cnt_next   = '0;
                        state_next = S_ENTER;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
            end

            S_ENTER: begin
                if (submit) begin
                    state_next = S_CHECK;
                end
            end

            S_CHECK: begin
                if (correct) begin
                    if (score_reg != '1) begin
                        score_next = score_reg + SCORE_ONE;
                    end
                    last_next = 1'b1;
                end else begin
                    if (lives_reg != 2'd0) begin
                        lives_next = lives_reg - 2'd1;
                    end
                    last_next = 1'b0;
                end
                cnt_next   = CNT_RESULT;
                state_next = S_RESULT;
            end

            S_RESULT: begin
                if (blinkTick) begin
                    if (cnt_reg <= CNT_ONE) begin
                        if (lives_reg == 2'd0) begin
                            cnt_next   = '0;
                            state_next = S_OVER;
                        end else begin
                            target_next = randInt;
                            cnt_next    = show_len;
                            state_next  = S_SHOW;
                        end
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
            end

            S_OVER: begin
                // Score is being cleared on this edge, so the new game starts at full show length.
                if (start) begin
                    score_next  = '0;
                    lives_next  = LIVES_INIT;
                    target_next = randInt;
                    cnt_next    = CNT_SHOW;
                    state_next  = S_SHOW;
                end
            end

            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Phase flags are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            target_reg <= '0;
            score_reg  <= '0;
            lives_reg  <= LIVES_INIT;
            last_reg   <= 1'b0;
            disp_reg   <= 1'b0;
            ready_reg  <= 1'b0;
            over_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            score_reg  <= score_next;
            lives_reg  <= lives_next;
            last_reg   <= last_next;
            disp_reg   <= (state_next == S_SHOW);
            ready_reg  <= (state_next == S_RESULT) || (state_next == S_OVER);
            over_reg   <= (state_next == S_OVER);
        end
    end

    assign targetInt    = target_reg;
    assign displayPhase = disp_reg;
    assign inputReady   = ready_reg;
    assign lastCorrect  = last_reg;
    assign score        = score_reg;
    assign livesLeft    = lives_reg;
    assign gameOver     = over_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer: reset, show/enter/check/result flow, game over and restart.
// Build with GAME_SPEEDUP_EN defined to exercise the shrinking show length instead of the default flow.
module tb_game_sequencer;

`ifdef GAME_SPEEDUP_EN
    localparam int TB_SHOW = 4;
`else
    localparam int TB_SHOW = 3;
`endif
    localparam int TB_RESULT = 2;
    localparam int TB_LIVES  = 2;
    localparam int TB_SW     = 8;
    localparam int SEL_DISP  = 0;
    localparam int SEL_OVER  = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             blinkTick;
    logic             start;
    logic             submit;
    logic [15:0]      randInt;
    logic             correct;
    logic [15:0]      targetInt;
    logic             displayPhase;
    logic             inputReady;
    logic             lastCorrect;
    logic [TB_SW-1:0] score;
    logic [1:0]       livesLeft;
    logic             gameOver;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int show_ticks   = 0;
    int res_ticks    = 0;

    game_sequencer #(
        .SHOW_TICKS  (TB_SHOW),
        .RESULT_TICKS(TB_RESULT),
        .LIVES       (TB_LIVES),
        .SCORE_W     (TB_SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .blinkTick   (blinkTick),
        .start       (start),
        .submit      (submit),
        .randInt     (randInt),
        .correct     (correct),
        .targetInt   (targetInt),
        .displayPhase(displayPhase),
        .inputReady  (inputReady),
        .lastCorrect (lastCorrect),
        .score       (score),
        .livesLeft   (livesLeft),
        .gameOver    (gameOver)
    );

    always #5 clk = ~clk;

    // One clock: counts ticks the DUT sees in SHOW/RESULT, then drives the next blink and clears pulses.
    task automatic step();
        bit pre_show;
        bit pre_res;
        pre_show = displayPhase && blinkTick;
        pre_res  = inputReady && blinkTick && !gameOver;
        @(posedge clk);
        #1;
        if (pre_show) show_ticks++;
        if (pre_res)  res_ticks++;
        cyc++;
        blinkTick = (cyc % 10 == 0);
        start     = 1'b0;
        submit    = 1'b0;
    endtask

    task automatic wait_until(input int sel, input logic val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            logic cur;
            cur = (sel == SEL_DISP) ? displayPhase : gameOver;
            if (cur === val) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        randInt = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            step();
        end
        tests_run++; if (livesLeft !== 2'd2) begin tests_failed++; $display("FAIL reset_lives: got %0d expected 2", livesLeft); end
        tests_run++; if (score !== 8'd0) begin tests_failed++; $display("FAIL reset_score: got %0d expected 0", score); end
        tests_run++; if (targetInt !== 16'h0000) begin tests_failed++; $display("FAIL reset_target: got %h expected 0000", targetInt); end
        tests_run++; if ({displayPhase, inputReady, lastCorrect, gameOver} !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 0000", {displayPhase, inputReady, lastCorrect, gameOver}); end
        rst = 1'b1;
        step();
        step();
        tests_run++; if ({displayPhase, inputReady, gameOver} !== 3'b000 || targetInt !== 16'h0000) begin tests_failed++; $display("FAIL reset_idle_hold: got flags %b target %h expected 000 0000", {displayPhase, inputReady, gameOver}, targetInt); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_start();
        bit ok;
        randInt = 16'hFF12;
        if (blinkTick) step();
        start = 1'b1;
        step();
        tests_run++; if (targetInt !== 16'hFF12) begin tests_failed++; $display("FAIL start_target: got %h expected ff12", targetInt); end
        tests_run++; if (displayPhase !== 1'b1) begin tests_failed++; $display("FAIL start_display: got %b expected 1", displayPhase); end
        randInt    = 16'h1234;
        show_ticks = 0;
        repeat (3) step();
        submit = 1'b1;
        step();
        wait_until(SEL_DISP, 1'b0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL show_timeout: got displayPhase %b expected 0 within budget", displayPhase); end
        tests_run++; if (show_ticks !== 3) begin tests_failed++; $display("FAIL show_length: got %0d ticks expected 3", show_ticks); end
        tests_run++; if (targetInt !== 16'hFF12 || inputReady !== 1'b0) begin tests_failed++; $display("FAIL enter_entry: got target %h ready %b expected ff12 0", targetInt, inputReady); end
        $display("[TB] test_start done");
    endtask

    task automatic test_correct();
        bit ok;
        randInt = 16'h5555;
        start   = 1'b1;
        step();
        repeat (25) step();
        tests_run++; if ({displayPhase, inputReady} !== 2'b00 || targetInt !== 16'hFF12) begin tests_failed++; $display("FAIL enter_hold: got flags %b target %h expected 00 ff12", {displayPhase, inputReady}, targetInt); end
        correct = 1'b1;
        submit  = 1'b1;
        step();
        tests_run++; if (inputReady !== 1'b0 || score !== 8'd0) begin tests_failed++; $display("FAIL check_cycle: got ready %b score %0d expected 0 0", inputReady, score); end
        step();
        tests_run++; if (score !== 8'd1 || lastCorrect !== 1'b1 || inputReady !== 1'b1) begin tests_failed++; $display("FAIL correct_update: got score %0d last %b ready %b expected 1 1 1", score, lastCorrect, inputReady); end
        res_ticks = 0;
        randInt   = 16'hA5C3;
        wait_until(SEL_DISP, 1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL result_timeout: got displayPhase %b expected 1 within budget", displayPhase); end
        tests_run++; if (res_ticks !== 2) begin tests_failed++; $display("FAIL result_length: got %0d ticks expected 2", res_ticks); end
        tests_run++; if (targetInt !== 16'hA5C3 || inputReady !== 1'b0 || score !== 8'd1) begin tests_failed++; $display("FAIL next_round: got target %h ready %b score %0d expected a5c3 0 1", targetInt, inputReady, score); end
        $display("[TB] test_correct done");
    endtask

    task automatic test_lose_lives();
        bit ok;
        wait_until(SEL_DISP, 1'b0, ok);
        correct = 1'b0;
        submit  = 1'b1;
        step();
        step();
        tests_run++; if (livesLeft !== 2'd1 || lastCorrect !== 1'b0 || score !== 8'd1) begin tests_failed++; $display("FAIL wrong_one: got lives %0d last %b score %0d expected 1 0 1", livesLeft, lastCorrect, score); end
        wait_until(SEL_DISP, 1'b1, ok);
        wait_until(SEL_DISP, 1'b0, ok);
        submit = 1'b1;
        step();
        step();
        tests_run++; if (livesLeft !== 2'd0 || gameOver !== 1'b0) begin tests_failed++; $display("FAIL wrong_two: got lives %0d over %b expected 0 0", livesLeft, gameOver); end
        wait_until(SEL_OVER, 1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL over_timeout: got gameOver %b expected 1 within budget", gameOver); end
        tests_run++; if (inputReady !== 1'b1 || displayPhase !== 1'b0 || score !== 8'd1 || lastCorrect !== 1'b0) begin tests_failed++; $display("FAIL over_state: got ready %b disp %b score %0d last %b expected 1 0 1 0", inputReady, displayPhase, score, lastCorrect); end
        submit = 1'b1;
        step();
        repeat (12) step();
        tests_run++; if (gameOver !== 1'b1 || livesLeft !== 2'd0) begin tests_failed++; $display("FAIL over_hold: got over %b lives %0d expected 1 0", gameOver, livesLeft); end
        randInt = 16'h0F0F;
        start   = 1'b1;
        step();
        tests_run++; if (gameOver !== 1'b0 || score !== 8'd0 || livesLeft !== 2'd2) begin tests_failed++; $display("FAIL restart_counts: got over %b score %0d lives %0d expected 0 0 2", gameOver, score, livesLeft); end
        tests_run++; if (displayPhase !== 1'b1 || targetInt !== 16'h0F0F) begin tests_failed++; $display("FAIL restart_show: got disp %b target %h expected 1 0f0f", displayPhase, targetInt); end
        $display("[TB] test_lose_lives done");
    endtask

    task automatic test_rst_mid_show();
        bit ok;
        repeat (5) step();
        rst = 1'b0;
        step();
        tests_run++; if ({displayPhase, inputReady, gameOver} !== 3'b000 || targetInt !== 16'h0000 || livesLeft !== 2'd2) begin tests_failed++; $display("FAIL mid_reset: got flags %b target %h lives %0d expected 000 0000 2", {displayPhase, inputReady, gameOver}, targetInt, livesLeft); end
        rst = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            if (blinkTick) break;
            step();
        end
        tests_run++; if (blinkTick !== 1'b1) begin tests_failed++; $display("FAIL tick_align: got blinkTick %b expected 1 within budget", blinkTick); end
        randInt    = 16'h7E57;
        start      = 1'b1;
        show_ticks = 0;
        step();
        tests_run++; if (displayPhase !== 1'b1 || targetInt !== 16'h7E57) begin tests_failed++; $display("FAIL tick_start: got disp %b target %h expected 1 7e57", displayPhase, targetInt); end
        wait_until(SEL_DISP, 1'b0, ok);
        tests_run++; if (!ok || show_ticks !== 3) begin tests_failed++; $display("FAIL tick_start_length: got %0d ticks (done %b) expected 3", show_ticks, ok); end
        $display("[TB] test_rst_mid_show done");
    endtask

`ifdef GAME_SPEEDUP_EN
    task automatic test_speedup();
        bit ok;
        int exp_len [4] = '{4, 3, 2, 2};
        randInt = 16'h2222;
        if (blinkTick) step();
        start = 1'b1;
        step();
        correct = 1'b1;
        for (int r = 0; r < 4; r++) begin
            show_ticks = 0;
            wait_until(SEL_DISP, 1'b0, ok);
            tests_run++; if (!ok || show_ticks !== exp_len[r]) begin tests_failed++; $display("FAIL speedup_round%0d: got %0d ticks expected %0d", r, show_ticks, exp_len[r]); end
            submit = 1'b1;
            step();
            wait_until(SEL_DISP, 1'b1, ok);
        end
        $display("[TB] test_speedup done");
    endtask
`endif

    initial begin
        rst       = 1'b0;
        blinkTick = 1'b0;
        start     = 1'b0;
        submit    = 1'b0;
        randInt   = 16'h0000;
        correct   = 1'b0;
        test_reset();
`ifdef GAME_SPEEDUP_EN
        test_speedup();
`else
        test_start();
        test_correct();
        test_lose_lives();
        test_rst_mid_show();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Round controller for the memorization game. It latches a target from the free-running `randnum` generator and sequences the show, enter, check and result phases. It drives `displayPhase` and `inputReady` into `display`, and keeps score and lives. The block sits between `clockdiv`/`randnum`/`checkInput` and `display`, and replaces the static phase and ready stimulus used so far.

## Interface
Parameters:
- `SHOW_TICKS`, 6: number of `blinkTick` pulses the target is shown.
- `RESULT_TICKS`, 4: number of `blinkTick` pulses the result is shown.
- `LIVES`, 3: lives at game start (1..3).
- `SCORE_W`, 8: width of the score counter.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `blinkTick` in 1: one-`clk`-wide pulse per blink period, synchronous to `clk`.
- `start` in 1: debounced one-cycle pulse that starts or restarts a game.
- `submit` in 1: debounced one-cycle pulse meaning the user entry is complete.
- `randInt` in 16: free-running random value.
- `correct` in 1: combinational match from `checkInput` (`userInt` vs `targetInt`).
- `targetInt` out 16: latched round target, feeds `checkInput` and `display`.
- `displayPhase` out 1: high while the target is shown.
- `inputReady` out 1: high while the result is shown.
- `lastCorrect` out 1: outcome of the most recent check.
- `score` out `SCORE_W`: rounds passed.
- `livesLeft` out 2: remaining lives.
- `gameOver` out 1: high in the OVER state.

## Operation
- States: IDLE, SHOW, ENTER, CHECK, RESULT, OVER. All outputs are registered.
- Reset (`rst`=0 at a `clk` edge) puts the block in IDLE with these output values:
  - `targetInt`=0, `displayPhase`=0, `inputReady`=0, `lastCorrect`=0
  - `score`=0, `livesLeft`=`LIVES`, `gameOver`=0, tick counter=0
- IDLE: waits for `start`. On `start`: latch `randInt` into `targetInt`, load counter=`SHOW_TICKS`, go to SHOW.
- SHOW: `displayPhase`=1.
  - Each `blinkTick` decrements the counter.
  - A `blinkTick` seen while counter==1 moves to ENTER.
  - `start` and `submit` are ignored.
- ENTER: `displayPhase`=0, `inputReady`=0.
  - `submit` moves to CHECK.
  - `blinkTick` and `start` are ignored. There is no timeout.
- CHECK: lasts one cycle and samples `correct`.
  - `correct`=1: `score` increments, saturating at all-ones; `lastCorrect`=1.
  - `correct`=0: `livesLeft` decrements, never below 0; `lastCorrect`=0.
  - Load counter=`RESULT_TICKS`, go to RESULT.
- RESULT: `inputReady`=1. The counter runs as in SHOW. On expiry:
  - `livesLeft`==0: go to OVER.
  - Otherwise: latch a new `randInt`, load counter=`SHOW_TICKS`, go to SHOW with `score` and `livesLeft` kept.
- OVER: `gameOver`=1, `inputReady`=1; `lastCorrect` and `score` hold.
  - `start` clears `score`, sets `livesLeft`=`LIVES` and `gameOver`=0, latches a new `randInt`, and goes to SHOW.
- `start` is honored only in IDLE and OVER. A mid-game restart is done with `rst` only.

## Timing
- `start` sampled at edge N: `targetInt` and `displayPhase`=1 are valid after edge N.
- Ticks coincident with a state-entry edge are not counted. Counting begins with the first `blinkTick` after entry.
- Show duration is exactly `SHOW_TICKS` blink ticks. The SHOW→ENTER edge is the one that samples the last tick.
- `submit` sampled at edge N:
  - CHECK is active during cycle N..N+1.
  - `correct` is sampled at edge N+1.
  - `score`/`livesLeft`/`lastCorrect` are updated and `inputReady`=1 after edge N+1.
- `userInt` must be stable from `submit` through the CHECK edge. That is the caller's responsibility.
- Simultaneous events:
  - `start`+`blinkTick` in IDLE: start wins and the tick is not counted.
  - `submit`+`blinkTick` in ENTER: submit wins.
- `rst` low overrides all inputs on the same edge, including mid-SHOW or mid-RESULT.

## Configuration
- `GAME_SPEEDUP_EN` defined: the show duration for each round is `max(2, SHOW_TICKS - score)`. Round 1 uses `SHOW_TICKS`.
- `GAME_SPEEDUP_EN` undefined: every round uses `SHOW_TICKS`; no subtractor or compare is built.

## Test plan
Parameters for all scenarios: `SHOW_TICKS`=3, `RESULT_TICKS`=2, `LIVES`=2, `blinkTick` every 10 clocks.
- Reset: hold `rst`=0 for 3 clocks with `start` pulsing → `livesLeft`=2, `score`=0, all flags 0, state IDLE.
- `start` with `randInt`=16'hFF12 → `targetInt`=16'hFF12, `displayPhase`=1 for exactly 3 ticks, then ENTER.
- `submit` with `correct`=1 → `score`=1, `lastCorrect`=1, `inputReady`=1 for 2 ticks, then SHOW with a new `targetInt`.
- Two rounds with `correct`=0 → `livesLeft` goes 2→1→0, then `gameOver`=1. A subsequent `start` gives `score`=0, `livesLeft`=2, SHOW.
- `rst`=0 mid-SHOW, and `start`+`blinkTick` on the same cycle in IDLE → immediate IDLE, then a full 3-tick show.
- `GAME_SPEEDUP_EN` with `SHOW_TICKS`=4 and 3 correct rounds → show lengths 4, 3, 2, 2 ticks.
